display_base_ctrl: RTL

//  Sequencer for the result/remainder 7-segment display path. Registers ALU results.

---
 rtl/display_base_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/display_base_ctrl.sv
// Base-select sequencer and result/remainder latch for the 7-segment display decoders.
// The base advances on a debounced button press or an auto-scroll tick, whichever comes first.
module display_base_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter int          SCROLL_CYCLES   = 100000000,
  parameter logic [2:0]  OP_DIV          = 3'b011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_base_n,
  input  logic        auto_scroll_en,
  input  logic        result_valid,
  input  logic [2:0]  op_code,
  input  logic [15:0] result_in,
  input  logic [7:0]  resto_in,
  output logic [15:0] data_out,
  output logic [7:0]  resto_out,
  output logic [1:0]  sel,
  output logic        resto_enable,
  output logic        base_changed
);

  localparam int DbW = $clog2(DEBOUNCE_CYCLES);
  localparam int ScW = $clog2(SCROLL_CYCLES);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ScW-1:0] ScLast = ScW'(SCROLL_CYCLES - 1);

  // State encoding doubles as the sel code driven to the decoders.
  typedef enum logic [1:0] {
    DEC = 2'b11,
    HEX = 2'b01,
    OCT = 2'b10
  } base_e;

  logic           sync1_q, sync2_q;
  logic           db_q, db_d, dbPrev_q;
  logic [DbW-1:0] dbCnt_q, dbCnt_d;
  logic [ScW-1:0] scCnt_q, scCnt_d;
  base_e          state_q, state_d;
  logic           baseChanged_q;
  logic           press, terminal, advance;
  logic [15:0]    data_q;
  logic [7:0]     resto_q;
  logic           restoEn_q;

  always_comb begin
    db_d    = db_q;
    dbCnt_d = '0;
    if (sync2_q != db_q) begin
      if (dbCnt_q == DbLast) begin
        db_d = sync2_q;
      end else begin
        dbCnt_d = dbCnt_q + DbW'(1);
      end
    end
  end

  assign press    = dbPrev_q & ~db_q;
  assign terminal = auto_scroll_en && (scCnt_q == ScLast);
  assign advance  = press | terminal;

  // A manual press restarts the full scroll interval.
  always_comb begin
    scCnt_d = scCnt_q + ScW'(1);
    if (!auto_scroll_en || press || terminal) begin
      scCnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_q     <= 1'b1;
      dbPrev_q <= 1'b1;
      dbCnt_q  <= '0;
      scCnt_q  <= '0;
    end else begin
      sync1_q  <= btn_base_n;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      dbPrev_q <= db_q;
      dbCnt_q  <= dbCnt_d;
      scCnt_q  <= scCnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= DEC;
      baseChanged_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      baseChanged_q <= advance;
    end
  end

  always_comb begin
    state_d = state_q;
    if (advance) begin
      unique case (state_q)
        DEC:     state_d = HEX;
        HEX:     state_d = OCT;
        OCT:     state_d = DEC;
        default: state_d = DEC;
      endcase
    end
  end

  always_comb begin
    sel          = state_q;
    base_changed = baseChanged_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      resto_q   <= '0;
      restoEn_q <= 1'b0;
    end else if (result_valid) begin
      data_q    <= result_in;
      resto_q   <= resto_in;
      restoEn_q <= (op_code == OP_DIV);
    end
  end

  assign data_out     = data_q;
  assign resto_out    = resto_q;
  assign resto_enable = restoEn_q;

endmodule
